// File: rtl/al_exec_if.sv
// Instruction handshake and retirement strobes between the decode stage and al_exec_unit.
interface al_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        done;
  logic        err;

  modport master (output in_valid, in_instr, input in_ready, done, err);
  modport slave  (input in_valid, in_instr, output in_ready, done, err);
endinterface

// File: rtl/al_exec_unit.sv
// Clocked ALU + GPR file with status flags, iterative shift-add multiplier,
// illegal-instruction detection and a combinational debug read port.
module al_exec_unit #(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  al_exec_if.slave          cmd,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] sgpr,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int AW  = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
  localparam int MSB = DATA_W - 1;

  typedef enum logic [4:0] {
    OP_MOVSGPR = 5'd0, OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_OR,
    OP_AND, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOT
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  function automatic logic in_range(input logic [4:0] a);
    return 32'(a) < unsigned'(NUM_GPR);
  endfunction

  state_e state, state_n;

  logic [DATA_W-1:0]   gpr [NUM_GPR];
  logic [4:0]          oper, rdst, rsrc1, rsrc2;
  logic                imm_mode;
  logic [15:0]         isrc;
  logic [DATA_W-1:0]   rs1_val, rs2_val, op_b, src_un, res, diff;
  logic [DATA_W:0]     sum_ext;
  logic                carry, ovf, illegal, is_mul, accept;

  logic [2*DATA_W-1:0] m_cand, m_acc, m_next;
  logic [DATA_W-1:0]   m_plier, m_lo, m_hi;
  logic [4:0]          m_rdst;
  logic [5:0]          m_cnt;
  logic                m_last;

  assign oper     = cmd.in_instr[31:27];
  assign rdst     = cmd.in_instr[26:22];
  assign rsrc1    = cmd.in_instr[21:17];
  assign imm_mode = cmd.in_instr[16];
  assign rsrc2    = cmd.in_instr[15:11];
  assign isrc     = cmd.in_instr[15:0];

  assign cmd.in_ready = (state == S_IDLE);
  assign accept       = cmd.in_valid && cmd.in_ready;
  assign is_mul       = (oper == OP_MUL);
  assign illegal      = (oper > OP_NOT) || !in_range(rdst) || !in_range(rsrc1)
                        || (!imm_mode && !in_range(rsrc2));

  always_comb begin
    rs1_val  = '0;
    rs2_val  = '0;
    dbg_data = '0;
    if (in_range(rsrc1))    rs1_val  = gpr[rsrc1[AW-1:0]];
    if (in_range(rsrc2))    rs2_val  = gpr[rsrc2[AW-1:0]];
    if (in_range(dbg_addr)) dbg_data = gpr[dbg_addr[AW-1:0]];
    op_b   = imm_mode ? DATA_W'(isrc) : rs2_val;
    src_un = imm_mode ? op_b : rs1_val;
  end

  always_comb begin
    sum_ext = {1'b0, rs1_val} + {1'b0, op_b};
    diff    = rs1_val - op_b;
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op_e'(oper))
      OP_MOVSGPR: res = sgpr;
      OP_MOV:     res = src_un;
      OP_ADD: begin
        res   = sum_ext[MSB:0];
        carry = sum_ext[DATA_W];
        ovf   = (rs1_val[MSB] == op_b[MSB]) && (sum_ext[MSB] != rs1_val[MSB]);
      end
      OP_SUB: begin
        res   = diff;
        carry = rs1_val < op_b;
        ovf   = (rs1_val[MSB] != op_b[MSB]) && (diff[MSB] != rs1_val[MSB]);
      end
      OP_OR:   res = rs1_val | op_b;
      OP_AND:  res = rs1_val & op_b;
      OP_XOR:  res = rs1_val ^ op_b;
      OP_XNOR: res = ~(rs1_val ^ op_b);
      OP_NAND: res = ~(rs1_val & op_b);
      OP_NOR:  res = ~(rs1_val | op_b);
      OP_NOT:  res = ~src_un;
      default: res = '0;
    endcase
  end

  // Final partial product is folded in combinationally so the writeback lands
  // on the DATA_W-th edge after accept.
  assign m_next = m_plier[0] ? (m_acc + m_cand) : m_acc;
  assign m_lo   = m_next[MSB:0];
  assign m_hi   = m_next[2*DATA_W-1:DATA_W];
  assign m_last = (state == S_MUL) && (m_cnt == 6'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept && is_mul && !illegal) state_n = S_MUL;
      S_MUL:   if (m_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(NUM_GPR); i++) gpr[i] <= '0;
      sgpr     <= '0;
      flags    <= '0;
      cmd.done <= 1'b0;
      cmd.err  <= 1'b0;
      m_cand   <= '0;
      m_acc    <= '0;
      m_plier  <= '0;
      m_rdst   <= '0;
      m_cnt    <= '0;
    end else begin
      cmd.done <= 1'b0;
      cmd.err  <= 1'b0;
      if (accept) begin
        cmd.err  <= illegal;
        cmd.done <= illegal || !is_mul;
        if (!illegal && is_mul) begin
          m_cand  <= {{DATA_W{1'b0}}, rs1_val};
          m_plier <= op_b;
          m_acc   <= '0;
          m_cnt   <= '0;
          m_rdst  <= rdst;
        end else if (!illegal) begin
          gpr[rdst[AW-1:0]] <= res;
          flags             <= {res == '0, res[MSB], carry, ovf};
        end
      end else if (state == S_MUL) begin
        m_acc   <= m_next;
        m_cand  <= m_cand << 1;
        m_plier <= m_plier >> 1;
        m_cnt   <= m_cnt + 6'd1;
        if (m_last) begin
          gpr[m_rdst[AW-1:0]] <= m_lo;
          sgpr                <= m_hi;
          flags               <= {m_lo == '0, m_lo[MSB], m_hi != '0, 1'b0};
          cmd.done            <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/al_exec_unit.md
Name: al_exec_unit

Overview:
- Clocked, parametrised successor to the combinational ALU and register-file block.
- Accepts 32-bit instructions over a valid/ready handshake and executes them against an internal GPR file and the special register SGPR.
- Adds status flags, an iterative multi-cycle multiplier, illegal-opcode detection and a debug read port.
- Sits between the instruction fetch/decode stage and the writeback/debug logic of the processor core.

Parameters:
- DATA_W, 16, GPR and SGPR width in bits; legal range 16..32.
- NUM_GPR, 32, number of GPRs; legal range 2..32. Register addresses of NUM_GPR or above are illegal.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, instruction valid.
- in_ready, output, 1, unit can accept an instruction.
- in_instr, input, 32, instruction: [31:27] oper, [26:22] rdst, [21:17] rsrc1, [16] imm_mode, [15:11] rsrc2, [15:0] isrc.
- done, output, 1, one-cycle pulse when an instruction retires.
- err, output, 1, one-cycle pulse, coincident with done, when an illegal instruction retires.
- flags, output, 4, {zero, sign, carry, overflow}.
- sgpr, output, DATA_W, current SGPR value.
- dbg_addr, input, 5, debug GPR read address.
- dbg_data, output, DATA_W, combinational read of GPR[dbg_addr]; reads 0 if the address is out of range.

Behaviour:
- Reset: all GPRs, SGPR, flags, done and err = 0; in_ready = 1; FSM = IDLE. Reset asserted mid-multiply aborts the multiply with no writeback.
- Accept condition: in_valid && in_ready at a rising edge. The instruction is ignored when in_valid is low.
- Operand B = GPR[rsrc2] when imm_mode = 0; isrc zero-extended to DATA_W when imm_mode = 1.
- Opcodes:
  - 00000 movsgpr: GPR[rdst] = SGPR.
  - 00001 mov: GPR[rdst] = B (imm) or GPR[rsrc1] (reg).
  - 00010 add, 00011 sub, 00100 mul.
  - 00101 or, 00110 and, 00111 xor, 01000 xnor, 01001 nand, 01010 nor.
  - 01011 not: GPR[rdst] = ~B (imm) or ~GPR[rsrc1] (reg).
  - 01100..11111: illegal.
- Single-cycle ops (all except mul):
  - GPR[rdst] and flags are written on the accept edge.
  - done = 1 for the following cycle. in_ready stays 1, so one instruction per cycle is sustained.
  - A back-to-back read of a register written on the previous edge sees the new value; the register file is the only state, so no forwarding is needed.
- Flags:
  - zero = (result == 0); sign = result[DATA_W-1].
  - add: carry = carry-out; overflow = signed overflow.
  - sub: carry = borrow (GPR[rsrc1] < B, unsigned); overflow = signed overflow.
  - Logical, not, mov, movsgpr: carry = 0, overflow = 0.
- Multiply:
  - FSM states IDLE -> MUL -> IDLE. On accept, latch the operands and rdst, then enter MUL with in_ready = 0.
  - Shift-add runs one bit per cycle for DATA_W cycles.
  - On the edge ending the last iteration: GPR[rdst] = product[DATA_W-1:0]; SGPR = product[2*DATA_W-1:DATA_W]; zero/sign from the low half; carry = (high half != 0); overflow = 0. Return to IDLE with in_ready = 1.
  - done pulses in the next cycle. Total latency is DATA_W cycles from accept to GPR update.
  - Operands are latched at accept, so rdst == rsrc1 is safe.
- Illegal instructions: an illegal opcode, or rdst/rsrc1/rsrc2 ≥ NUM_GPR (rsrc2 checked only when imm_mode = 0), performs no GPR, SGPR or flag update. done and err both pulse in the cycle after accept.
- Arithmetic is modulo 2^DATA_W, and the isrc field overlaps rsrc2 exactly as the instruction format defines.
- in_ready is a registered function of the FSM state only; it never depends combinationally on in_valid.

Test Plan:
- Reset, then mov imm to r1 = 0x0005 and add imm r2 = r1 + 0x000A, issued back-to-back -> r2 = 0x000F, done high two consecutive cycles, flags = 0000.
- r3 = 0xFFFF; add r4 = r3 + r1 (r1 = 1) -> r4 = 0x0000, flags zero = 1, carry = 1, overflow = 0. Then r5 = 0x7FFF + 1 -> 0x8000, sign = 1, overflow = 1.
- mul r6 = r3 (0xFFFF) * imm 0x0002, DATA_W = 16 -> in_ready low 16 cycles; r6 = 0xFFFE, SGPR = 0x0001, carry = 1. Then movsgpr r7 -> r7 = 0x0001.
- Opcode 01111, and separately rdst = 20 with NUM_GPR = 16 -> err and done pulse, all GPRs/flags unchanged. in_valid held high during a mul is not accepted until in_ready returns to 1.
- rst_n dropped at cycle 5 of a multiply -> GPRs and SGPR = 0, in_ready = 1 asynchronously, no done pulse after release.
- DATA_W = 32 build: mul 0x00010000 * 0x00010000 -> low half = 0, SGPR = 0x00000001, zero = 1, latency 32 cycles.
